// File: rtl/fpu_wb_port_scheduler_pkg.sv
// Shared types and latency constants for the FP
// writeback-port scheduler.
package fpu_sched_pkg;

  localparam int FAST_LAT  = 2;
  localparam int FMA_LAT   = 4;
  localparam int TOINT_LAT = 2;
  localparam int MAXLAT    = FMA_LAT;
  localparam int TAG_W     = 6;

  typedef enum logic [1:0] {
    FU_FAST,
    FU_FMA,
    FU_TOINT,
    FU_DIV
  } fu_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_KILLED
  } div_state_e;

endpackage

// File: rtl/fpu_wb_port_scheduler_if.sv
// Issue, div/sqrt and writeback signals between the
// FP issue queue, the FPU pipes and the scheduler.
interface fpu_sched_if #(
  parameter int TAG_W = 6
);

  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_uopc;
  logic [TAG_W-1:0] req_tag;
  logic             req_fastpipe;
  logic             req_fma;
  logic             req_toint;
  logic             flush;

  logic             fpu_valid;
  logic [1:0]       fpu_sel;
  logic [6:0]       fpu_uopc;
  logic [TAG_W-1:0] fpu_tag;

  logic             div_req_valid;
  logic             div_req_ready;
  logic             div_resp_valid;
  logic             div_resp_ready;

  logic             fwb_valid;
  logic [TAG_W-1:0] fwb_tag;
  logic             fwb_src;
  logic             iwb_valid;
  logic [TAG_W-1:0] iwb_tag;

  modport master (
    output req_valid, req_uopc, req_tag,
    output req_fastpipe, req_fma, req_toint,
    output flush, div_req_ready, div_resp_valid,
    input  req_ready, fpu_valid, fpu_sel,
    input  fpu_uopc, fpu_tag,
    input  div_req_valid, div_resp_ready,
    input  fwb_valid, fwb_tag, fwb_src,
    input  iwb_valid, iwb_tag
  );

  modport slave (
    input  req_valid, req_uopc, req_tag,
    input  req_fastpipe, req_fma, req_toint,
    input  flush, div_req_ready, div_resp_valid,
    output req_ready, fpu_valid, fpu_sel,
    output fpu_uopc, fpu_tag,
    output div_req_valid, div_resp_ready,
    output fwb_valid, fwb_tag, fwb_src,
    output iwb_valid, iwb_tag
  );

endinterface

// File: rtl/fpu_wb_slot_ring.sv
// Writeback reservation ring: slots shift toward the
// head each cycle; slot 0 is the writeback this cycle.
module fpu_wb_slot_ring #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic             clr,
  output logic             head_v,
  output logic [TAG_W-1:0] head_tag,
  output logic [DEPTH-1:0] v
);

  logic [DEPTH-1:0]            v_q, v_n;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_n;

  always_comb begin
    v_n   = {1'b0, v_q[DEPTH-1:1]};
    tag_n = {{TAG_W{1'b0}}, tag_q[DEPTH-1:1]};
    if (we) begin
      v_n[widx]   = 1'b1;
      tag_n[widx] = wtag;
    end
    if (clr) v_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      tag_q <= '0;
    end else begin
      v_q   <= v_n;
      tag_q <= tag_n;
    end
  end

  assign head_v   = v_q[0];
  assign head_tag = tag_q[0];
  assign v        = v_q;

endmodule

// File: rtl/fpu_wb_port_scheduler.sv
// FP issue scheduler: holds uops off writeback-port
// collisions and sequences the iterative div/sqrt unit.
module fpu_wb_port_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int TAG_W = fpu_sched_pkg::TAG_W
) (
  input logic        clock,
  input logic        reset,
  fpu_sched_if.slave io
);

  localparam int FIW = (MAXLAT > 1)
                     ? $clog2(MAXLAT) : 1;
  localparam int IIW = (TOINT_LAT > 1)
                     ? $clog2(TOINT_LAT) : 1;

  fu_sel_e    cls;
  div_state_e state_q, state_n;

  logic [TAG_W-1:0] div_tag_q, div_tag_n;
  logic             rdy, fire, pipe_fire;
  logic             fp_we, int_we;
  logic [FIW-1:0]   fp_widx;
  logic             fp_head_v, int_head_v;
  logic [TAG_W-1:0] fp_head_tag, int_head_tag;
  logic [MAXLAT-1:0]    fp_v;
  logic [TOINT_LAT-1:0] int_v;
  logic [MAXLAT:0]      fp_vpad;
  logic             div_fire, resp_fire, div_wb;

  logic             fpu_valid_q;
  logic [1:0]       fpu_sel_q;
  logic [6:0]       fpu_uopc_q;
  logic [TAG_W-1:0] fpu_tag_q;

  always_comb begin
    cls = FU_DIV;
    unique case (1'b1)
      io.req_fastpipe: cls = FU_FAST;
      io.req_fma:      cls = FU_FMA;
      io.req_toint:    cls = FU_TOINT;
      default:         cls = FU_DIV;
    endcase
  end

  // A latency-L op claims slot L-1 after the shift,
  // so slot L must be empty now; slot MAXLAT never exists.
  assign fp_vpad = {1'b0, fp_v};

  always_comb begin
    rdy = 1'b0;
    unique case (cls)
      FU_FAST:  rdy = ~fp_vpad[FAST_LAT];
      FU_FMA:   rdy = ~fp_vpad[FMA_LAT];
      FU_TOINT: rdy = 1'b1;
      FU_DIV:   rdy = (state_q == DIV_IDLE)
                    & io.div_req_ready;
      default:  rdy = 1'b0;
    endcase
  end

  assign io.req_ready = rdy & ~io.flush & ~reset;
  assign fire      = io.req_valid & io.req_ready;
  assign pipe_fire = fire & (cls != FU_DIV);

  assign fp_we  = fire
                & ((cls == FU_FAST) | (cls == FU_FMA));
  assign int_we = fire & (cls == FU_TOINT);
  assign fp_widx = (cls == FU_FMA)
                 ? FIW'(FMA_LAT - 1)
                 : FIW'(FAST_LAT - 1);

  fpu_wb_slot_ring #(
    .DEPTH(MAXLAT),
    .TAG_W(TAG_W)
  ) u_fp_ring (
    .clk     (clock),
    .rst     (reset),
    .we      (fp_we),
    .widx    (fp_widx),
    .wtag    (io.req_tag),
    .clr     (io.flush),
    .head_v  (fp_head_v),
    .head_tag(fp_head_tag),
    .v       (fp_v)
  );

  fpu_wb_slot_ring #(
    .DEPTH(TOINT_LAT),
    .TAG_W(TAG_W)
  ) u_int_ring (
    .clk     (clock),
    .rst     (reset),
    .we      (int_we),
    .widx    (IIW'(TOINT_LAT - 1)),
    .wtag    (io.req_tag),
    .clr     (io.flush),
    .head_v  (int_head_v),
    .head_tag(int_head_tag),
    .v       (int_v)
  );

  assign io.div_req_valid = io.req_valid
                          & (cls == FU_DIV)
                          & (state_q == DIV_IDLE)
                          & ~io.flush & ~reset;
  assign div_fire = io.div_req_valid
                  & io.div_req_ready;

  // Div result yields the port to any pipe result.
  assign io.div_resp_ready =
      (state_q != DIV_IDLE)
    & ((state_q == DIV_KILLED) | ~fp_head_v);
  assign resp_fire = io.div_resp_valid
                   & io.div_resp_ready;
  assign div_wb = resp_fire
                & (state_q == DIV_BUSY) & ~io.flush;

  always_comb begin
    state_n   = state_q;
    div_tag_n = div_tag_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (div_fire) begin
          state_n   = DIV_BUSY;
          div_tag_n = io.req_tag;
        end
      end
      DIV_BUSY: begin
        if (resp_fire)     state_n = DIV_IDLE;
        else if (io.flush) state_n = DIV_KILLED;
      end
      DIV_KILLED: begin
        if (resp_fire) state_n = DIV_IDLE;
      end
      default: state_n = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      div_tag_q   <= '0;
      fpu_valid_q <= 1'b0;
      fpu_sel_q   <= '0;
      fpu_uopc_q  <= '0;
      fpu_tag_q   <= '0;
    end else begin
      state_q     <= state_n;
      div_tag_q   <= div_tag_n;
      fpu_valid_q <= pipe_fire;
      if (pipe_fire) begin
        fpu_sel_q  <= cls;
        fpu_uopc_q <= io.req_uopc;
        fpu_tag_q  <= io.req_tag;
      end
    end
  end

  assign io.fpu_valid = fpu_valid_q;
  assign io.fpu_sel   = fpu_sel_q;
  assign io.fpu_uopc  = fpu_uopc_q;
  assign io.fpu_tag   = fpu_tag_q;

  assign io.fwb_valid = fp_head_v | div_wb;
  assign io.fwb_tag   = fp_head_v ? fp_head_tag
                                  : div_tag_q;
  assign io.fwb_src   = ~fp_head_v & div_wb;
  assign io.iwb_valid = int_head_v;
  assign io.iwb_tag   = int_head_tag;

endmodule

// File: tb/tb_fpu_wb_port_scheduler.sv
// Directed bench with writeback/issue scoreboards
// checked by an independent negedge monitor.
module tb_fpu_wb_port_scheduler;
  import fpu_sched_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fpu_sched_if #(.TAG_W(6)) io ();

  fpu_wb_port_scheduler #(.TAG_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .io   (io.slave)
  );

  typedef struct {
    int         cyc;
    logic [5:0] tag;
    logic       src;
  } wb_t;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [5:0] tag;
    logic [6:0] uopc;
  } iss_t;

  wb_t  fwb_q[$];
  wb_t  iwb_q[$];
  iss_t fpu_q[$];

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm, input int c);
    n_run++;
    n_fail++;
    $display("FAIL %s: got none want entry due cycle %0d (cycle %0d)",
             nm, c, cyc);
  endtask

  always @(negedge clock) begin
    wb_t  e;
    iss_t f;
    if (!reset) begin
      while (fwb_q.size() > 0 && fwb_q[0].cyc < cyc) begin
        miss("fwb_missing", fwb_q[0].cyc);
        void'(fwb_q.pop_front());
      end
      while (iwb_q.size() > 0 && iwb_q[0].cyc < cyc) begin
        miss("iwb_missing", iwb_q[0].cyc);
        void'(iwb_q.pop_front());
      end
      while (fpu_q.size() > 0 && fpu_q[0].cyc < cyc) begin
        miss("fpu_missing", fpu_q[0].cyc);
        void'(fpu_q.pop_front());
      end
      if (io.fwb_valid) begin
        if (fwb_q.size() == 0) begin
          chk("fwb_unexpected", io.fwb_valid, 0);
        end else begin
          e = fwb_q.pop_front();
          chk("fwb_cycle", cyc, e.cyc);
          chk("fwb_tag", io.fwb_tag, e.tag);
          chk("fwb_src", io.fwb_src, e.src);
        end
      end
      if (io.iwb_valid) begin
        if (iwb_q.size() == 0) begin
          chk("iwb_unexpected", io.iwb_valid, 0);
        end else begin
          e = iwb_q.pop_front();
          chk("iwb_cycle", cyc, e.cyc);
          chk("iwb_tag", io.iwb_tag, e.tag);
        end
      end
      if (io.fpu_valid) begin
        if (fpu_q.size() == 0) begin
          chk("fpu_unexpected", io.fpu_valid, 0);
        end else begin
          f = fpu_q.pop_front();
          chk("fpu_cycle", cyc, f.cyc);
          chk("fpu_sel", io.fpu_sel, f.sel);
          chk("fpu_tag", io.fpu_tag, f.tag);
          chk("fpu_uopc", io.fpu_uopc, f.uopc);
        end
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  task automatic clr_req();
    io.req_valid    = 1'b0;
    io.req_fastpipe = 1'b0;
    io.req_fma      = 1'b0;
    io.req_toint    = 1'b0;
  endtask

  // Writebacks due after the current (flush) cycle die.
  task automatic kill_after();
    wb_t keep[$];
    keep = {};
    foreach (fwb_q[i])
      if (fwb_q[i].cyc <= cyc) keep.push_back(fwb_q[i]);
    fwb_q = keep;
    keep = {};
    foreach (iwb_q[i])
      if (iwb_q[i].cyc <= cyc) keep.push_back(iwb_q[i]);
    iwb_q = keep;
  endtask

  // c: 0 fast, 1 fma, 2 toint, 3 div
  task automatic offer(input int c,
                       input logic [5:0] tag,
                       input logic exp_rdy,
                       input string nm);
    logic [6:0] u;
    u = {1'b0, tag} + 7'h10;
    io.req_valid    = 1'b1;
    io.req_fastpipe = (c == 0);
    io.req_fma      = (c == 1);
    io.req_toint    = (c == 2);
    io.req_tag      = tag;
    io.req_uopc     = u;
    if (exp_rdy) begin
      if (c == 0) begin
        fwb_q.push_back('{cyc + 2, tag, 1'b0});
        fpu_q.push_back('{cyc + 1, 2'd0, tag, u});
      end else if (c == 1) begin
        fwb_q.push_back('{cyc + 4, tag, 1'b0});
        fpu_q.push_back('{cyc + 1, 2'd1, tag, u});
      end else if (c == 2) begin
        iwb_q.push_back('{cyc + 2, tag, 1'b0});
        fpu_q.push_back('{cyc + 1, 2'd2, tag, u});
      end
    end
    @(negedge clock);
    chk({nm, "_ready"}, io.req_ready, exp_rdy);
    if (c == 3)
      chk({nm, "_div_valid"}, io.div_req_valid, exp_rdy);
    next();
    clr_req();
  endtask

  task automatic div_resp(input logic [5:0] tag,
                          input logic exp_wb,
                          input string nm);
    io.div_resp_valid = 1'b1;
    if (exp_wb) fwb_q.push_back('{cyc, tag, 1'b1});
    @(negedge clock);
    chk({nm, "_resp_ready"}, io.div_resp_ready, 1);
    next();
    io.div_resp_valid = 1'b0;
  endtask

  initial begin
    clr_req();
    io.req_tag        = '0;
    io.req_uopc       = '0;
    io.flush          = 1'b0;
    io.div_req_ready  = 1'b1;
    io.div_resp_valid = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_fwb_valid", io.fwb_valid, 0);
    chk("rst_iwb_valid", io.iwb_valid, 0);
    chk("rst_fpu_valid", io.fpu_valid, 0);
    chk("rst_div_req_valid", io.div_req_valid, 0);
    chk("rst_resp_ready", io.div_resp_ready, 0);
    next();
    reset = 1'b0;
    next();

    // FMA then a colliding fastpipe
    offer(1, 6'd5, 1'b1, "fma5");
    idle(1);
    offer(0, 6'd6, 1'b0, "fast6_blocked");
    offer(0, 6'd6, 1'b1, "fast6");
    idle(4);

    // back-to-back fastpipe, plus a to-int
    offer(0, 6'd1, 1'b1, "fast1");
    offer(0, 6'd2, 1'b1, "fast2");
    offer(0, 6'd3, 1'b1, "fast3");
    offer(2, 6'd20, 1'b1, "tint20");
    idle(4);

    // div result stalled by an FMA result
    offer(3, 6'd9, 1'b1, "div9");
    offer(1, 6'd7, 1'b1, "fma7");
    offer(3, 6'd10, 1'b0, "div10_busy");
    idle(2);
    io.div_resp_valid = 1'b1;
    @(negedge clock);
    chk("div9_stalled_resp_ready", io.div_resp_ready, 0);
    chk("div9_stalled_src", io.fwb_src, 0);
    next();
    div_resp(6'd9, 1'b1, "div9");
    offer(3, 6'd10, 1'b1, "div10");
    div_resp(6'd10, 1'b1, "div10");
    idle(2);

    // div killed by flush
    offer(3, 6'd11, 1'b1, "div11");
    io.flush = 1'b1;
    kill_after();
    next();
    io.flush = 1'b0;
    offer(3, 6'd12, 1'b0, "div12_killed");
    idle(1);
    div_resp(6'd11, 1'b0, "div11_killed");
    offer(3, 6'd12, 1'b1, "div12");
    div_resp(6'd12, 1'b1, "div12");
    idle(2);

    // flush kills in-flight fastpipe and to-int
    offer(0, 6'd13, 1'b1, "fast13");
    io.flush = 1'b1;
    kill_after();
    offer(2, 6'd4, 1'b0, "tint4_flush");
    io.flush = 1'b0;
    offer(2, 6'd14, 1'b1, "tint14");
    io.flush = 1'b1;
    kill_after();
    next();
    io.flush = 1'b0;
    idle(4);

    // async reset mid-operation
    offer(3, 6'd22, 1'b1, "div22");
    offer(1, 6'd21, 1'b1, "fma21");
    io.req_valid    = 1'b1;
    io.req_fastpipe = 1'b1;
    io.req_tag      = 6'd30;
    #1;
    fwb_q = {};
    iwb_q = {};
    fpu_q = {};
    reset = 1'b1;
    #1;
    chk("arst_fpu_valid", io.fpu_valid, 0);
    chk("arst_fwb_valid", io.fwb_valid, 0);
    chk("arst_resp_ready", io.div_resp_ready, 0);
    chk("arst_req_ready", io.req_ready, 0);
    clr_req();
    idle(2);
    reset = 1'b0;
    offer(0, 6'd23, 1'b1, "fast23_post_rst");
    @(negedge clock);
    chk("post_rst_resp_ready", io.div_resp_ready, 0);
    next();
    offer(3, 6'd24, 1'b1, "div24_post_rst");
    div_resp(6'd24, 1'b1, "div24");
    idle(6);

    chk("fwb_q_drained", fwb_q.size(), 0);
    chk("iwb_q_drained", iwb_q.size(), 0);
    chk("fpu_q_drained", fpu_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
